// File: rtl/multdiv_pkg.sv
// multdiv_pkg
// Shared definitions for the iterative multiply/divide unit: FSM state type,
// word width, iteration count, the most negative word and a magnitude helper.
// No ports (package).
package multdiv_pkg;

   localparam int WORD_W     = 32;
   localparam int ITER_COUNT = 32;
   localparam int CNT_W      = $clog2(ITER_COUNT);

   // Most negative two's complement word; dividing it by -1 is the only
   // divide whose quotient does not fit in a word.
   localparam logic [WORD_W-1:0] INT_MIN = {1'b1, {(WORD_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Unsigned magnitude of a two's complement word. INT_MIN maps to
   // 0x80000000, which is still correct when read as unsigned.
   function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] value);
      return value[WORD_W-1] ? ({WORD_W{1'b0}} - value) : value;
   endfunction

endpackage

// File: rtl/multdiv_if.sv
// multdiv_if
// Bundle of operand, control and result signals between the execute stage
// (master) and the multiply/divide unit (slave).
//   data_operandA  [31:0] master->slave  multiplicand / dividend
//   data_operandB  [31:0] master->slave  multiplier / divisor
//   ctrl_MULT             master->slave  one-cycle multiply start
//   ctrl_DIV              master->slave  one-cycle divide start
//   data_result    [31:0] slave->master  product low word / quotient
//   data_exception        slave->master  overflow or divide-by-zero
//   data_resultRDY        slave->master  one-cycle result-valid pulse
//   busy                  slave->master  operation in flight
interface multdiv_if;
   import multdiv_pkg::*;

   logic [WORD_W-1:0] data_operandA;
   logic [WORD_W-1:0] data_operandB;
   logic              ctrl_MULT;
   logic              ctrl_DIV;
   logic [WORD_W-1:0] data_result;
   logic              data_exception;
   logic              data_resultRDY;
   logic              busy;

   modport master (
      output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      input  data_result, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      output data_result, data_exception, data_resultRDY, busy
   );

endinterface

// File: rtl/multdiv_counter.sv
// multdiv_counter
// Iteration counter for the multiply/divide unit.
//   clock       master clock
//   reset       synchronous active-high clear
//   i_clear     synchronous clear (new operation starting)
//   i_enable    advance by one iteration
//   o_terminal  high while the count equals ITER_COUNT-1 (last iteration)
module multdiv_counter
   import multdiv_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_terminal
);

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

   logic [CNT_W-1:0] r_count;

   // Clear has priority over enable so a start always begins at iteration 0.
   always_ff @(posedge clock) begin
      if (reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + CNT_ONE;
      end
   end

   assign o_terminal = (r_count == CNT_LAST);

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit
// Fixed-latency 32-bit signed multiply / divide unit. A start pulse latches
// the operands; 32 iterations later data_resultRDY pulses for one cycle with
// data_result and data_exception valid. A new start at any time aborts the
// operation in flight.
//   clock  master clock, rising edge
//   reset  synchronous active-high clear
//   bus    multdiv_if.slave (operands, ctrl_MULT/ctrl_DIV, result, flags)
// Build option: define MULTDIV_DIV_EN to compile in the restoring divider.
// Without it, a divide request completes on the next edge with result 0 and
// the exception flag set.
module multdiv_unit
   import multdiv_pkg::*;
(
   input  logic     clock,
   input  logic     reset,
   multdiv_if.slave bus
);

   state_t r_state;
   state_t w_nextState;

   logic w_start;
   logic w_clear;
   logic w_enable;
   logic w_terminal;

   logic [WORD_W-1:0]   r_result;
   logic                r_exception;
   logic                r_negate;

   logic [2*WORD_W-1:0] r_mcand;
   logic [WORD_W-1:0]   r_mplier;
   logic [2*WORD_W-1:0] r_acc;

   logic [WORD_W-1:0]   w_absA;
   logic [WORD_W-1:0]   w_absB;
   logic [2*WORD_W-1:0] w_addend;
   logic [2*WORD_W-1:0] w_accNext;
   logic [2*WORD_W-1:0] w_product;
   logic                w_mulOvf;

   assign w_start = bus.ctrl_MULT || bus.ctrl_DIV;
   assign w_absA  = magnitude(bus.data_operandA);
   assign w_absB  = magnitude(bus.data_operandB);

   multdiv_counter u_counter (
      .clock      (clock),
      .reset      (reset),
      .i_clear    (w_clear),
      .i_enable   (w_enable),
      .o_terminal (w_terminal)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state and counter control. A start in any state restarts the
   // counter and wins over normal sequencing, which is how aborts happen.
   always_comb begin
      w_nextState = r_state;
      w_clear     = 1'b0;
      w_enable    = 1'b0;
      if (w_start) begin
         w_clear = 1'b1;
         if (bus.ctrl_MULT) begin
            w_nextState = MUL;
         end else begin
`ifdef MULTDIV_DIV_EN
            w_nextState = DIV;
`else
            w_nextState = DONE;
`endif
         end
      end else begin
         case (r_state)
            IDLE: w_nextState = IDLE;
            MUL, DIV: begin
               w_enable = 1'b1;
               if (w_terminal) begin
                  w_nextState = DONE;
               end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
         endcase
      end
   end

   // Shift-add step. The final step is folded into the sign correction so
   // the result register is written on the same edge that enters DONE.
   assign w_addend  = r_mplier[0] ? r_mcand : {(2*WORD_W){1'b0}};
   assign w_accNext = r_acc + w_addend;
   assign w_product = r_negate ? ({(2*WORD_W){1'b0}} - w_accNext) : w_accNext;
   assign w_mulOvf  = (w_product[2*WORD_W-1:WORD_W] != {WORD_W{w_product[WORD_W-1]}});

`ifdef MULTDIV_DIV_EN
   logic [WORD_W-1:0] r_rem;
   logic [WORD_W-1:0] r_quot;
   logic [WORD_W-1:0] r_divisor;
   logic              r_divZero;

   logic [WORD_W:0]   w_remShift;
   logic [WORD_W:0]   w_diff;
   logic              w_fits;
   logic [WORD_W-1:0] w_remNext;
   logic [WORD_W-1:0] w_quotNext;
   logic [WORD_W-1:0] w_quotSigned;
   logic              w_divOvf;

   // Restoring step: shift the next dividend bit into the partial remainder
   // and keep the subtraction only when it does not go negative. r_quot holds
   // the unconsumed dividend bits at the top and quotient bits at the bottom.
   assign w_remShift   = {r_rem, r_quot[WORD_W-1]};
   assign w_diff       = w_remShift - {1'b0, r_divisor};
   assign w_fits       = ~w_diff[WORD_W];
   assign w_remNext    = w_fits ? w_diff[WORD_W-1:0] : w_remShift[WORD_W-1:0];
   assign w_quotNext   = {r_quot[WORD_W-2:0], w_fits};
   assign w_quotSigned = r_negate ? ({WORD_W{1'b0}} - w_quotNext) : w_quotNext;
   // A magnitude of 2^31 is only representable when the result is negative.
   assign w_divOvf     = (w_quotNext == INT_MIN) && !r_negate;
`endif

   // Datapath registers. Both datapaths are loaded on any start; the state
   // decides which one iterates. Outside a start or an active iteration the
   // result and flag simply hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_result    <= '0;
         r_exception <= 1'b0;
         r_negate    <= 1'b0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
`ifdef MULTDIV_DIV_EN
         r_rem       <= '0;
         r_quot      <= '0;
         r_divisor   <= '0;
         r_divZero   <= 1'b0;
`endif
      end else if (w_start) begin
         r_negate <= bus.data_operandA[WORD_W-1] ^ bus.data_operandB[WORD_W-1];
         r_mcand  <= {{WORD_W{1'b0}}, w_absA};
         r_mplier <= w_absB;
         r_acc    <= '0;
`ifdef MULTDIV_DIV_EN
         r_rem     <= '0;
         r_quot    <= w_absA;
         r_divisor <= w_absB;
         r_divZero <= (bus.data_operandB == {WORD_W{1'b0}});
`else
         if (!bus.ctrl_MULT) begin
            r_result    <= '0;
            r_exception <= 1'b1;
         end
`endif
      end else begin
         case (r_state)
            MUL: begin
               r_acc    <= w_accNext;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               if (w_terminal) begin
                  r_result    <= w_product[WORD_W-1:0];
                  r_exception <= w_mulOvf;
               end
            end
`ifdef MULTDIV_DIV_EN
            DIV: begin
               r_rem  <= w_remNext;
               r_quot <= w_quotNext;
               if (w_terminal) begin
                  r_result    <= r_divZero ? {WORD_W{1'b0}} : w_quotSigned;
                  r_exception <= r_divZero | w_divOvf;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.data_result    = r_result;
   assign bus.data_exception = r_exception;
   assign bus.data_resultRDY = (r_state == DONE);
   assign bus.busy           = (r_state == MUL) || (r_state == DIV);

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit
// Self-checking bench for multdiv_unit: directed scenarios plus randomized
// operations compared against a plain-arithmetic reference model.
// Follows the DUT build option MULTDIV_DIV_EN for divide expectations.
module tb_multdiv_unit;

   logic clock = 1'b0;
   logic reset;

   int checks = 0;
   int errors = 0;

   multdiv_if dutIf();

   multdiv_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (dutIf)
   );

   // 10 time-unit clock; the bench drives and samples on the falling edge.
   always #5 clock = ~clock;

   // Safety net so the run always terminates.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed time limit reached, expected completion");
      $fatal(1, "[TB] timeout");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Reference model from the arithmetic definition: full 64-bit signed
   // product, and truncating signed division with its two special cases.
   // lat is the number of rising edges after the start edge before RDY.
   function automatic void refModel(input bit isDiv, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] res,
                                    output logic exc, output int lat);
      longint p;
      int     ia;
      int     ib;
      ia = a;
      ib = b;
      if (!isDiv) begin
         p   = longint'($signed(a)) * longint'($signed(b));
         res = p[31:0];
         exc = (p != longint'($signed(p[31:0])));
         lat = 32;
      end else begin
`ifdef MULTDIV_DIV_EN
         lat = 32;
         if (ib == 0) begin
            res = 32'd0;
            exc = 1'b1;
         end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'h8000_0000;
            exc = 1'b1;
         end else begin
            res = ia / ib;
            exc = 1'b0;
         end
`else
         lat = 0;
         res = 32'd0;
         exc = 1'b1;
`endif
      end
   endfunction

   // Issue one operation (called on a falling edge), scramble the operand
   // inputs afterwards, then measure latency/busy and check the result.
   task automatic applyStimulus(input bit isDiv, input logic [31:0] a,
                                input logic [31:0] b, input string tag);
      logic [31:0] expRes;
      logic        expExc;
      int          expLat;
      int          edges;
      int          busyCycles;
      bit          seen;
      refModel(isDiv, a, b, expRes, expExc, expLat);
      dutIf.data_operandA = a;
      dutIf.data_operandB = b;
      dutIf.ctrl_MULT     = !isDiv;
      dutIf.ctrl_DIV      = isDiv;
      @(posedge clock);
      @(negedge clock);
      dutIf.ctrl_MULT     = 1'b0;
      dutIf.ctrl_DIV      = 1'b0;
      dutIf.data_operandA = $urandom();
      dutIf.data_operandB = $urandom();
      edges      = 0;
      busyCycles = 0;
      seen       = 1'b0;
      while (!seen && edges < 40) begin
         if (dutIf.data_resultRDY) begin
            seen = 1'b1;
         end else begin
            if (dutIf.busy) busyCycles++;
            @(posedge clock);
            @(negedge clock);
            edges++;
         end
      end
      checkOutput({tag, " latency"}, edges, expLat);
      checkOutput({tag, " busy cycles"}, busyCycles, expLat);
      checkOutput({tag, " busy at rdy"}, {31'd0, dutIf.busy}, 32'd0);
      checkOutput({tag, " result"}, dutIf.data_result, expRes);
      checkOutput({tag, " exception"}, {31'd0, dutIf.data_exception}, {31'd0, expExc});
      @(posedge clock);
      @(negedge clock);
      checkOutput({tag, " rdy pulse"}, {31'd0, dutIf.data_resultRDY}, 32'd0);
      checkOutput({tag, " result hold"}, dutIf.data_result, expRes);
   endtask

   // Operand mix that favours sign and width corners.
   function automatic logic [31:0] pickOperand();
      logic [31:0] corner [5];
      corner[0] = 32'h0000_0000;
      corner[1] = 32'h0000_0001;
      corner[2] = 32'hFFFF_FFFF;
      corner[3] = 32'h8000_0000;
      corner[4] = 32'h7FFF_FFFF;
      case ($urandom_range(0, 3))
         0:       return $urandom();
         1:       return 32'(int'($urandom_range(0, 200)) - 100);
         2:       return corner[$urandom_range(0, 4)];
         default: return 32'(int'($urandom_range(0, 65535)) - 32768);
      endcase
   endfunction

   initial begin
      int rdyCount;
      reset               = 1'b1;
      dutIf.data_operandA = '0;
      dutIf.data_operandB = '0;
      dutIf.ctrl_MULT     = 1'b0;
      dutIf.ctrl_DIV      = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("reset result", dutIf.data_result, 32'd0);
      checkOutput("reset exception", {31'd0, dutIf.data_exception}, 32'd0);
      checkOutput("reset rdy", {31'd0, dutIf.data_resultRDY}, 32'd0);
      checkOutput("reset busy", {31'd0, dutIf.busy}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Directed scenarios.
      applyStimulus(1'b0, 32'd7, 32'hFFFF_FFFA, "mul 7*-6");
      applyStimulus(1'b0, 32'h0001_0000, 32'h0001_0000, "mul ovf");
      applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7, "div -100/7");
      applyStimulus(1'b1, 32'd5, 32'd0, "div by zero");
      applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div intmin/-1");
      applyStimulus(1'b1, 32'h8000_0000, 32'd1, "div intmin/1");
      applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, "div 7/-2");
      applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "mul intmin*-1");
      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul -1*-1");

      // Abort: multiply started, divide issued ten edges later.
      dutIf.data_operandA = 32'd3;
      dutIf.data_operandB = 32'd4;
      dutIf.ctrl_MULT     = 1'b1;
      @(posedge clock);
      @(negedge clock);
      dutIf.ctrl_MULT = 1'b0;
      rdyCount = 0;
      repeat (9) begin
         if (dutIf.data_resultRDY) rdyCount++;
         @(posedge clock);
         @(negedge clock);
      end
      checkOutput("abort no early rdy", rdyCount, 0);
      applyStimulus(1'b1, 32'd20, 32'd5, "abort div 20/5");

      // Make sure the result is nonzero before the reset test.
      applyStimulus(1'b0, 32'd1000, 32'd3, "mul pre-reset");

      // Reset during a multiply, coinciding with a new start request.
      dutIf.data_operandA = 32'd123456;
      dutIf.data_operandB = 32'd789;
      dutIf.ctrl_MULT     = 1'b1;
      @(posedge clock);
      @(negedge clock);
      dutIf.ctrl_MULT = 1'b0;
      repeat (14) begin
         @(posedge clock);
         @(negedge clock);
      end
      reset           = 1'b1;
      dutIf.ctrl_MULT = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset           = 1'b0;
      dutIf.ctrl_MULT = 1'b0;
      checkOutput("midreset result", dutIf.data_result, 32'd0);
      checkOutput("midreset exception", {31'd0, dutIf.data_exception}, 32'd0);
      checkOutput("midreset busy", {31'd0, dutIf.busy}, 32'd0);
      rdyCount = 0;
      repeat (40) begin
         if (dutIf.data_resultRDY || dutIf.busy) rdyCount++;
         @(posedge clock);
         @(negedge clock);
      end
      checkOutput("midreset stays idle", rdyCount, 0);
      applyStimulus(1'b0, 32'd123456, 32'd789, "mul post-reset");

      // Randomized operations.
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         bit          isDiv;
         isDiv = 1'($urandom_range(0, 1));
         a     = pickOperand();
         b     = pickOperand();
         applyStimulus(isDiv, a, b, isDiv ? "rand div" : "rand mul");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
